// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core-to-memory access bridge.
//   - RV32I load/store funct3 width codes
//   - bridge FSM state encoding
//   - default MMIO addresses and bus timeout
//   - helpers that classify an access as legal / misaligned
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0FFC;
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_0FF8;
  localparam int          DEF_TIMEOUT      = 16;

  // Stores accept only SB/SH/SW; loads additionally accept LBU/LHU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct3[1:0] encodes the access width for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory bridge.
// Ports:
//   funct3     in  3   RV32I load/store width code
//   addr_lo    in  2   byte offset within the word
//   store_data in  32  right-aligned store data from the core
//   load_word  in  32  raw word read from memory / MMIO
//   be         out 4   store byte enables (0 for non-store codes)
//   store_word out 32  store data replicated across all lanes
//   load_data  out 32  extracted and sign/zero-extended load data
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = load_word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  // Replicating the data means memory can simply honour be without
  // needing its own shifter.
  always_comb begin
    be         = 4'b0000;
    store_word = store_data;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
      end
      F3_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        store_word = {2{store_data[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_bridge.sv
// Bridge between the multicycle core's memory port and the unified memory.
// Turns a held core request into a req/ack memory transaction with a
// bounded wait, formats lanes, decodes the console and halt MMIO words,
// and reports misaligned / illegal / timed-out accesses on core_err.
//
// Handshakes:
//   core side: core_req is held by the core until core_ready; core_ready is
//     a one-cycle completion pulse, core_err/core_rdata are valid with it.
//   mem side: mem_req and all mem_* fields are registered and held stable
//     until the cycle mem_ack is sampled high (mem_rdata valid that cycle).
//
// Ports:
//   clk, reset (async, active-low)
//   core_req/we/addr/wdata/funct3 in ; core_ready/rdata/err out
//   mem_req/we/addr/wdata/be out ; mem_ack/mem_rdata in
//   con_valid/con_data out : console byte pulse
//   halted out              : sticky halt flag
//   dbg_state out           : current FSM state (state_t encoding)
module mem_access_bridge
  import riscv_mem_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter int          TIMEOUT      = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic        core_ready,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     f3_q;
  logic [1:0]     lo_q;
  logic [31:0]    rdata_q;

  logic        hit_halt, hit_con, hit_mmio, bad, timed_out;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [31:0] al_word, al_wdata, al_load;
  logic [3:0]  al_be;

  // Classification of the request presented at the core port.
  always_comb begin
    hit_halt  = (core_addr[31:2] == HALT_ADDR[31:2]);
    hit_con   = (core_addr[31:2] == CONSOLE_ADDR[31:2]);
    hit_mmio  = hit_halt || hit_con;
    bad       = !f3_legal(core_we, core_funct3)
             || misaligned(core_funct3, core_addr[1:0])
             || (hit_mmio && core_we && !(core_funct3 == F3_B || core_funct3 == F3_W));
    timed_out = (cnt_q == CW'(TIMEOUT - 1));
  end

  // One aligner serves both phases: in IDLE it formats the incoming store
  // and any MMIO load word, in BUS it formats the memory read using the
  // fields captured at accept time.
  always_comb begin
    if (state_q == ST_IDLE) begin
      al_f3   = core_funct3;
      al_lo   = core_addr[1:0];
      al_word = hit_halt ? {31'b0, halted} : 32'h0;
    end else begin
      al_f3   = f3_q;
      al_lo   = lo_q;
      al_word = mem_rdata;
    end
  end

  mem_lane_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .store_data (core_wdata),
    .load_word  (al_word),
    .be         (al_be),
    .store_word (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req) begin
          if (bad)           state_d = ST_ERR;
          else if (hit_mmio) state_d = ST_RESP;
          else               state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ack)        state_d = ST_RESP;
        else if (timed_out) state_d = ST_ERR;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      rdata_q   <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      con_valid <= 1'b0;
      con_data  <= 8'h00;
      halted    <= 1'b0;
    end else begin
      con_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (core_req && !bad) begin
            if (hit_mmio) begin
              // MMIO completes without touching memory; the store side
              // effect lands on this accept edge.
              rdata_q <= core_we ? 32'h0 : al_load;
              if (core_we && hit_halt) halted <= 1'b1;
              if (core_we && hit_con) begin
                con_valid <= 1'b1;
                con_data  <= core_wdata[7:0];
              end
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= core_we;
              mem_addr  <= {core_addr[31:2], 2'b00};
              mem_wdata <= core_we ? al_wdata : 32'h0;
              mem_be    <= core_we ? al_be : 4'b0000;
              f3_q      <= core_funct3;
              lo_q      <= core_addr[1:0];
            end
          end
        end
        ST_BUS: begin
          if (mem_ack) begin
            rdata_q <= mem_we ? 32'h0 : al_load;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign core_ready = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign core_err   = (state_q == ST_ERR);
  assign core_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_bridge.sv
module tb_mem_access_bridge;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_funct3;
  logic        core_ready;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        halted;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_access_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_funct3 (core_funct3),
    .core_ready  (core_ready),
    .core_rdata  (core_rdata),
    .core_err    (core_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .con_valid   (con_valid),
    .con_data    (con_data),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;     // mem_rdata returned with ack
    logic        bus;     // expect a memory transaction
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;      // expected core_rdata
    logic        con;
    logic [7:0]  cdat;
    logic        halt;    // expected halted after the access
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrd, input logic bus, input logic err,
                              input logic [3:0] be, input logic [31:0] mwd,
                              input logic [31:0] rd, input logic con, input logic [7:0] cdat,
                              input logic halt);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrd = mrd;
    v.bus = bus; v.err = err; v.be = be; v.mwd = mwd; v.rd = rd; v.con = con;
    v.cdat = cdat; v.halt = halt;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the bridge idle.
  task automatic run_vec(input vec_t v);
    core_req    = 1'b1;
    core_we     = v.we;
    core_addr   = v.addr;
    core_wdata  = v.wdata;
    core_funct3 = v.f3;
    @(posedge clk); #1;
    if (v.bus) begin
      chk({v.name, ".mem_req"},  {31'b0, mem_req}, 32'd1);
      chk({v.name, ".mem_we"},   {31'b0, mem_we}, {31'b0, v.we});
      chk({v.name, ".mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      chk({v.name, ".mem_be"},   {28'b0, mem_be}, {28'b0, v.be});
      chk({v.name, ".mem_wdata"}, mem_wdata, v.mwd);
      chk({v.name, ".state_bus"}, {30'b0, dbg_state}, 32'd1);
      chk({v.name, ".early_ready"}, {31'b0, core_ready}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = v.mrd;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      chk({v.name, ".mem_req_drop"}, {31'b0, mem_req}, 32'd0);
    end else begin
      chk({v.name, ".no_mem_req"}, {31'b0, mem_req}, 32'd0);
    end
    chk({v.name, ".ready"}, {31'b0, core_ready}, 32'd1);
    chk({v.name, ".err"},   {31'b0, core_err}, {31'b0, v.err});
    chk({v.name, ".rdata"}, core_rdata, v.rd);
    chk({v.name, ".con_valid"}, {31'b0, con_valid}, {31'b0, v.con});
    if (v.con) chk({v.name, ".con_data"}, {24'b0, con_data}, {24'b0, v.cdat});
    chk({v.name, ".halted"}, {31'b0, halted}, {31'b0, v.halt});
    core_req = 1'b0;
    @(posedge clk); #1;
    chk({v.name, ".ready_pulse"}, {31'b0, core_ready}, 32'd0);
    chk({v.name, ".con_pulse"}, {31'b0, con_valid}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin : main
    int n;
    reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0;
    core_wdata = 32'h0; core_funct3 = 3'b000; mem_ack = 1'b0; mem_rdata = 32'h0;

    //        name        we  f3      addr          wdata         mrd           bus err be       mwd           rd            con cdat   halt
    vecs.push_back(mk("lw100",   0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 8'h00, 0));
    vecs.push_back(mk("lb103",   0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 8'h00, 0));
    vecs.push_back(mk("lbu103",  0, 3'b100, 32'h103, 32'h0,        32'h80FFFF7F, 1, 0, 4'b0000, 32'h0,        32'h00000080, 0, 8'h00, 0));
    vecs.push_back(mk("lh102",   0, 3'b001, 32'h102, 32'h0,        32'h80FFFF7F, 1, 0, 4'b0000, 32'h0,        32'hFFFF80FF, 0, 8'h00, 0));
    vecs.push_back(mk("lhu100",  0, 3'b101, 32'h100, 32'h0,        32'h80FFFF7F, 1, 0, 4'b0000, 32'h0,        32'h0000FF7F, 0, 8'h00, 0));
    vecs.push_back(mk("lb100",   0, 3'b000, 32'h100, 32'h0,        32'h80FFFF7F, 1, 0, 4'b0000, 32'h0,        32'h0000007F, 0, 8'h00, 0));
    vecs.push_back(mk("sb101",   1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        1, 0, 4'b0010, 32'hABABABAB, 32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("sh102",   1, 3'b001, 32'h102, 32'h00001234, 32'h0,        1, 0, 4'b1100, 32'h12341234, 32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("sw104",   1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,        1, 0, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("lw_mis",  0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("ld_f3_3", 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("sh_mis",  1, 3'b001, 32'h101, 32'h00005555, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("st_f3_4", 1, 3'b100, 32'h100, 32'h00005555, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("con_sw",  1, 3'b010, 32'hFF8, 32'h00000041, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 8'h41, 0));
    vecs.push_back(mk("con_sb",  1, 3'b000, 32'hFF9, 32'h00000142, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 8'h42, 0));
    vecs.push_back(mk("con_sh",  1, 3'b001, 32'hFF8, 32'h00000043, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("con_lw",  0, 3'b010, 32'hFF8, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("halt_lw0",0, 3'b010, 32'hFFC, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0));
    vecs.push_back(mk("halt_sw", 1, 3'b010, 32'hFFC, 32'h00000001, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 1));
    vecs.push_back(mk("halt_lw1",0, 3'b010, 32'hFFC, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h1,        0, 8'h00, 1));
    vecs.push_back(mk("post_lw", 0, 3'b010, 32'h200, 32'h0,        32'h13572468, 1, 0, 4'b0000, 32'h0,        32'h13572468, 0, 8'h00, 1));

    // Reset state
    #12;
    chk("rst.ready", {31'b0, core_ready}, 32'd0);
    chk("rst.mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst.halted", {31'b0, halted}, 32'd0);
    chk("rst.state", {30'b0, dbg_state}, 32'd0);
    chk("rst.rdata", core_rdata, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: ack withheld, mem_req must stay up for exactly 16 cycles.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h300; core_funct3 = 3'b010;
    @(posedge clk); #1;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to.req_cycles", n, 32'd16);
    chk("to.ready", {31'b0, core_ready}, 32'd1);
    chk("to.err", {31'b0, core_err}, 32'd1);
    chk("to.rdata", core_rdata, 32'h0);
    core_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("to.late_ack_ready", {31'b0, core_ready}, 32'd0);
    chk("to.late_ack_state", {30'b0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    chk("to.late_ack_ready2", {31'b0, core_ready}, 32'd0);

    // Async reset in the middle of a bus transaction.
    chk("pre_rst.halted", {31'b0, halted}, 32'd1);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h400; core_funct3 = 3'b010;
    @(posedge clk); #1;
    chk("mid.mem_req", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    core_req = 1'b0;
    #1;
    chk("mid.mem_req_drop", {31'b0, mem_req}, 32'd0);
    chk("mid.halted_clr", {31'b0, halted}, 32'd0);
    chk("mid.state", {30'b0, dbg_state}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    run_vec(mk("after_rst", 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 4'b0000,
               32'h0, 32'hDEADBEEF, 0, 8'h00, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
